// File: rtl/median_window_ctrl_if.sv
// Pixel stream, comparator-tree and median stream signals of the 3x3 median
// filter front end. The slave modport is the controller's view; the master
// modport is the surrounding datapath/source/sink view.
interface median_window_ctrl_if;
    logic [7:0] pix_in;
    logic       pix_valid;
    logic       sof;
    logic       pix_ready;
    logic [7:0] win1, win2, win3;
    logic [7:0] win4, win5, win6;
    logic [7:0] win7, win8, win9;
    logic       ldFilter;
    logic [1:0] selFilter;
    logic [7:0] med_in;
    logic [7:0] med_out;
    logic       med_valid;

    modport slave (
        input  pix_in, pix_valid, sof, med_in,
        output pix_ready,
        output win1, win2, win3, win4, win5, win6, win7, win8, win9,
        output ldFilter, selFilter, med_out, med_valid
    );

    modport master (
        output pix_in, pix_valid, sof, med_in,
        input  pix_ready,
        input  win1, win2, win3, win4, win5, win6, win7, win8, win9,
        input  ldFilter, selFilter, med_out, med_valid
    );
endinterface

// File: rtl/median_window_ctrl.sv
// 3x3 median filter front end: builds the neighbourhood from a raster stream
// using two line buffers, steps the external comparator tree through its three
// stages and presents the captured median as a valid-qualified stream.
module median_window_ctrl #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                 clk,
    input  logic                 rst,
    median_window_ctrl_if.slave  bus
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    typedef enum logic [2:0] {IDLE, S1, S2, S3, CAP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] col, cur_col, col_nxt;
    logic [RW-1:0] row, cur_row, row_nxt;
    logic          ready, accept, win_done;
    logic          ld;
    logic [1:0]    sel;
    logic [7:0]    win [9];
    logic [7:0]    linebuf0 [IMG_WIDTH];
    logic [7:0]    linebuf1 [IMG_WIDTH];
    logic [7:0]    lb0_rd, lb1_rd;
    logic [7:0]    med_q;
    logic          med_v;

    assign ready  = (state == IDLE) && !rst;
    assign accept = bus.pix_valid && ready;
    assign lb0_rd = linebuf0[cur_col];
    assign lb1_rd = linebuf1[cur_col];

    // Position of the pixel being offered (sof overrides the counters) and the next position
    always_comb begin
        cur_col  = bus.sof ? '0 : col;
        cur_row  = bus.sof ? '0 : row;
        col_nxt  = cur_col + CW'(1);
        row_nxt  = cur_row;
        if (cur_col == CW'(IMG_WIDTH - 1)) begin
            col_nxt = '0;
            row_nxt = (cur_row == RW'(IMG_HEIGHT - 1)) ? '0 : cur_row + RW'(1);
        end
        win_done = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
    end

    // Line buffers: column-wise vertical shift of the two previous lines (not reset)
    always_ff @(posedge clk) begin
        if (accept) begin
            linebuf1[cur_col] <= lb0_rd;
            linebuf0[cur_col] <= bus.pix_in;
        end
    end

    // Raster counters and the 3x3 window shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
            for (int unsigned i = 0; i < 9; i++) begin
                win[i] <= '0;
            end
        end else if (accept) begin
            col <= col_nxt;
            row <= row_nxt;
            for (int unsigned r = 0; r < 3; r++) begin
                win[3*r]     <= win[3*r + 1];
                win[3*r + 1] <= win[3*r + 2];
            end
            win[2] <= lb1_rd;
            win[5] <= lb0_rd;
            win[8] <= bus.pix_in;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and comparator-tree stage controls
    always_comb begin
        state_nxt = state;
        ld        = 1'b0;
        sel       = 2'd0;
        case (state)
            IDLE: if (accept && win_done) state_nxt = S1;
            S1: begin
                ld        = 1'b1;
                sel       = 2'd1;
                state_nxt = S2;
            end
            S2: begin
                ld        = 1'b1;
                sel       = 2'd2;
                state_nxt = S3;
            end
            S3: begin
                ld        = 1'b1;
                sel       = 2'd3;
                state_nxt = CAP;
            end
            CAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Median capture: one-cycle valid pulse following the CAP state
    always_ff @(posedge clk) begin
        if (rst) begin
            med_q <= '0;
            med_v <= 1'b0;
        end else begin
            med_v <= (state == CAP);
            if (state == CAP) begin
                med_q <= bus.med_in;
            end
        end
    end

    assign bus.pix_ready = ready;
    assign bus.ldFilter  = ld;
    assign bus.selFilter = sel;
    assign bus.med_out   = med_q;
    assign bus.med_valid = med_v;
    assign bus.win1 = win[0];
    assign bus.win2 = win[1];
    assign bus.win3 = win[2];
    assign bus.win4 = win[3];
    assign bus.win5 = win[4];
    assign bus.win6 = win[5];
    assign bus.win7 = win[6];
    assign bus.win8 = win[7];
    assign bus.win9 = win[8];
endmodule

// File: tb/tb_median_window_ctrl.sv
// Directed bench for median_window_ctrl on a 4x4 image with a behavioural
// three-stage comparator tree closing the loop through med_in.
module tb_median_window_ctrl;
    localparam int W    = 4;
    localparam int H    = 4;
    localparam int LOGN = 2048;

    logic clk = 1'b0;
    logic rst = 1'b1;

    median_window_ctrl_if bus();

    median_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Comparator tree model: result latched when the tree is in its last stage
    function automatic logic [7:0] median9(input logic [71:0] w);
        logic [7:0] a [9];
        logic [7:0] tmp;
        for (int i = 0; i < 9; i++) a[i] = w[i*8 +: 8];
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8 - i; j++)
                if (a[j] > a[j+1]) begin
                    tmp = a[j]; a[j] = a[j+1]; a[j+1] = tmp;
                end
        return a[4];
    endfunction

    logic [7:0] med_reg;
    always @(posedge clk) begin
        if (rst) med_reg <= 8'd0;
        else if (bus.ldFilter && bus.selFilter == 2'd3)
            med_reg <= median9({bus.win1, bus.win2, bus.win3, bus.win4, bus.win5,
                                bus.win6, bus.win7, bus.win8, bus.win9});
    end
    assign bus.med_in = med_reg;

    // Cycle log sampled mid-cycle
    logic       acc_log [LOGN];
    logic [7:0] pix_log [LOGN];
    logic       rdy_log [LOGN];
    logic       ld_log  [LOGN];
    logic [1:0] sel_log [LOGN];
    logic       mv_log  [LOGN];
    logic [7:0] mo_log  [LOGN];
    int         cyc     = 0;
    int         dbl_mv  = 0;
    logic       prev_mv = 1'b0;
    logic [7:0] med_q [$];

    always @(negedge clk) begin
        if (cyc < LOGN) begin
            acc_log[cyc] <= bus.pix_valid && bus.pix_ready;
            pix_log[cyc] <= bus.pix_in;
            rdy_log[cyc] <= bus.pix_ready;
            ld_log[cyc]  <= bus.ldFilter;
            sel_log[cyc] <= bus.selFilter;
            mv_log[cyc]  <= bus.med_valid;
            mo_log[cyc]  <= bus.med_out;
        end
        if (bus.med_valid) med_q.push_back(bus.med_out);
        if (bus.med_valid && prev_mv) dbl_mv <= dbl_mv + 1;
        prev_mv <= bus.med_valid;
        cyc     <= cyc + 1;
    end

    logic [7:0] stim     [64];
    logic       stim_sof [64];
    logic [7:0] exp_ramp [4] = '{8'd5, 8'd6, 8'd9, 8'd10};

    task automatic load_ramp(input int n);
        for (int i = 0; i < n; i++) begin
            stim[i]     = 8'(i % 16);
            stim_sof[i] = (i == 0);
        end
    endtask

    // Streams n pixels with pix_valid held high; entered and left at posedge+1
    task automatic run_stream(input int n, input bit drain, output int start_cyc);
        int   i = 0;
        int   guard = 0;
        logic rdy;
        start_cyc = cyc;
        med_q.delete();
        bus.pix_valid = 1'b1;
        bus.pix_in    = stim[0];
        bus.sof       = stim_sof[0];
        while (i < n && guard < 20 * n + 20) begin
            @(negedge clk);
            rdy = bus.pix_ready;
            guard++;
            @(posedge clk);
            #1;
            if (rdy) begin
                i++;
                if (i < n) begin
                    bus.pix_in = stim[i];
                    bus.sof    = stim_sof[i];
                end else begin
                    bus.pix_valid = 1'b0;
                    bus.sof       = 1'b0;
                end
            end
        end
        n_checks++;
        if (i !== n) begin
            n_fail++;
            $display("FAIL stream_timeout: accepted %0d, required %0d", i, n);
            bus.pix_valid = 1'b0;
            bus.sof       = 1'b0;
        end
        if (drain) begin
            repeat (8) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        bus.pix_valid = 1'b0;
        bus.pix_in    = 8'd0;
        bus.sof       = 1'b0;
        rst           = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.pix_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready_low: got %b, required 0", bus.pix_ready);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.pix_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready_high: got %b, required 1", bus.pix_ready);
        end
        n_checks++;
        if ({bus.ldFilter, bus.selFilter, bus.med_valid, bus.med_out} !== 12'd0) begin
            n_fail++; $display("FAIL reset_ctrl: ld=%b sel=%0d mv=%b mo=%0d, required all 0",
                               bus.ldFilter, bus.selFilter, bus.med_valid, bus.med_out);
        end
        n_checks++;
        if ({bus.win1, bus.win2, bus.win3, bus.win4, bus.win5, bus.win6, bus.win7,
             bus.win8, bus.win9} !== 72'd0) begin
            n_fail++; $display("FAIL reset_window: got %h, required 0",
                {bus.win1, bus.win2, bus.win3, bus.win4, bus.win5, bus.win6, bus.win7, bus.win8, bus.win9});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_ramp;
        int s;
        int t = -1;
        load_ramp(16);
        run_stream(16, 1'b1, s);
        n_checks++;
        if (med_q.size() !== 4) begin
            n_fail++; $display("FAIL ramp_count: got %0d medians, required 4", med_q.size());
        end
        for (int k = 0; k < 4 && k < med_q.size(); k++) begin
            n_checks++;
            if (med_q[k] !== exp_ramp[k]) begin
                n_fail++; $display("FAIL ramp_median[%0d]: got %0d, required %0d", k, med_q[k], exp_ramp[k]);
            end
        end
        for (int k = s; k < cyc; k++)
            if (t < 0 && acc_log[k] && pix_log[k] == 8'd10) t = k;
        n_checks++;
        if (t < 0) begin
            n_fail++; $display("FAIL latency_accept10: accept of pixel 10 not seen, required 1");
        end else begin
            for (int d = 1; d <= 3; d++) begin
                n_checks++;
                if (ld_log[t+d] !== 1'b1 || sel_log[t+d] !== 2'(d)) begin
                    n_fail++; $display("FAIL latency_stage T+%0d: ld=%b sel=%0d, required ld=1 sel=%0d",
                                       d, ld_log[t+d], sel_log[t+d], d);
                end
            end
            n_checks++;
            if (ld_log[t+4] !== 1'b0 || sel_log[t+4] !== 2'd0 || mv_log[t+4] !== 1'b0) begin
                n_fail++; $display("FAIL latency_cap T+4: ld=%b sel=%0d mv=%b, required 0 0 0",
                                   ld_log[t+4], sel_log[t+4], mv_log[t+4]);
            end
            n_checks++;
            if (mv_log[t+5] !== 1'b1 || mo_log[t+5] !== 8'd5) begin
                n_fail++; $display("FAIL latency_out T+5: mv=%b mo=%0d, required mv=1 mo=5",
                                   mv_log[t+5], mo_log[t+5]);
            end
        end
    endtask

    task automatic test_impulse;
        int s;
        for (int i = 0; i < 16; i++) begin
            stim[i]     = 8'd100;
            stim_sof[i] = (i == 0);
        end
        stim[5] = 8'd255;
        run_stream(16, 1'b1, s);
        n_checks++;
        if (med_q.size() !== 4) begin
            n_fail++; $display("FAIL impulse_count: got %0d medians, required 4", med_q.size());
        end
        for (int k = 0; k < med_q.size(); k++) begin
            n_checks++;
            if (med_q[k] !== 8'd100) begin
                n_fail++; $display("FAIL impulse_median[%0d]: got %0d, required 100", k, med_q[k]);
            end
        end
    endtask

    task automatic test_backpressure;
        int  s;
        int  lows = 0;
        int  accepts = 0;
        bit  stall;
        load_ramp(16);
        run_stream(16, 1'b1, s);
        for (int k = s; k < cyc - 1; k++) begin
            if (!rdy_log[k]) lows++;
            if (acc_log[k]) begin
                accepts++;
                stall = (pix_log[k] == 8'd10) || (pix_log[k] == 8'd11) ||
                        (pix_log[k] == 8'd14) || (pix_log[k] == 8'd15);
                n_checks++;
                if (rdy_log[k+1] !== !stall) begin
                    n_fail++; $display("FAIL bp_ready_after_pix%0d: got %b, required %b",
                                       pix_log[k], rdy_log[k+1], !stall);
                end
                if (stall) begin
                    n_checks++;
                    if ({rdy_log[k+1], rdy_log[k+2], rdy_log[k+3], rdy_log[k+4], rdy_log[k+5]} !== 5'b00001) begin
                        n_fail++; $display("FAIL bp_stall_pix%0d: ready T+1..T+5 = %b%b%b%b%b, required 00001",
                            pix_log[k], rdy_log[k+1], rdy_log[k+2], rdy_log[k+3], rdy_log[k+4], rdy_log[k+5]);
                    end
                end
            end
        end
        n_checks++;
        if (lows !== 16 || accepts !== 16) begin
            n_fail++; $display("FAIL bp_totals: ready-low cycles %0d accepts %0d, required 16 and 16", lows, accepts);
        end
    endtask

    task automatic test_reset_midop;
        int s;
        load_ramp(11);
        run_stream(11, 1'b0, s);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.ldFilter !== 1'b1 || bus.selFilter !== 2'd2 || bus.pix_ready !== 1'b0) begin
            n_fail++; $display("FAIL midrst_in_s2: ld=%b sel=%0d rdy=%b, required 1 2 0",
                               bus.ldFilter, bus.selFilter, bus.pix_ready);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.ldFilter, bus.selFilter, bus.med_valid, bus.med_out} !== 12'd0 || bus.pix_ready !== 1'b1) begin
            n_fail++; $display("FAIL midrst_outputs: ld=%b sel=%0d mv=%b mo=%0d rdy=%b, required 0 0 0 0 1",
                               bus.ldFilter, bus.selFilter, bus.med_valid, bus.med_out, bus.pix_ready);
        end
        n_checks++;
        if ({bus.win1, bus.win2, bus.win3, bus.win4, bus.win5, bus.win6, bus.win7,
             bus.win8, bus.win9} !== 72'd0) begin
            n_fail++; $display("FAIL midrst_window: window not cleared, required 0");
        end
        repeat (8) @(posedge clk);
        #1;
        n_checks++;
        if (med_q.size() !== 0) begin
            n_fail++; $display("FAIL midrst_no_valid: got %0d medians, required 0", med_q.size());
        end
        load_ramp(16);
        run_stream(16, 1'b1, s);
        n_checks++;
        if (med_q.size() !== 4) begin
            n_fail++; $display("FAIL midrst_ramp_count: got %0d, required 4", med_q.size());
        end
        for (int k = 0; k < 4 && k < med_q.size(); k++) begin
            n_checks++;
            if (med_q[k] !== exp_ramp[k]) begin
                n_fail++; $display("FAIL midrst_ramp[%0d]: got %0d, required %0d", k, med_q[k], exp_ramp[k]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int s;
        int d0;
        load_ramp(32);
        d0 = dbl_mv;
        run_stream(32, 1'b1, s);
        n_checks++;
        if (med_q.size() !== 8) begin
            n_fail++; $display("FAIL wrap_count: got %0d medians, required 8", med_q.size());
        end
        for (int k = 0; k < 8 && k < med_q.size(); k++) begin
            n_checks++;
            if (med_q[k] !== exp_ramp[k % 4]) begin
                n_fail++; $display("FAIL wrap_median[%0d]: got %0d, required %0d", k, med_q[k], exp_ramp[k % 4]);
            end
        end
        n_checks++;
        if (dbl_mv !== d0) begin
            n_fail++; $display("FAIL wrap_valid_pulse: %0d back-to-back med_valid cycles, required 0", dbl_mv - d0);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_impulse();
        test_backpressure();
        test_reset_midop();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
